ysyx_23060240_trap_ctrl: RTL
============================

YSYX_23060240_TRAP_CTRL -- requirements
Module: ysyx_23060240_trap_ctrl

Interface
REQ-001 SHALL have parameter ECALL_CAUSE, default 32'h0000000b, the value written to mcause on ecall.
REQ-002 SHALL have parameter MTVEC_ALIGN_MASK, default 32'hfffffffc, ANDed with mtvec to form the trap target.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req_ecall, input, 1, ecall decoded in the current instruction.
REQ-006 SHALL have port req_mret, input, 1, mret decoded in the current instruction.
REQ-007 SHALL have port pc, input, 32, PC of the current instruction.
REQ-008 SHALL have ports req_csr_wen (input, 1), req_csr_addr (input, 12) and req_csr_wdata (input, 32), the CSR write requested by a CSR instruction.
REQ-009 SHALL have port csr_rdata, input, 32, combinational read data from the CSR file at csr_addr.
REQ-010 SHALL have ports csr_addr (output, 12), csr_wdata (output, 32) and csr_wen (output, 1), which drive the single CSR-file port.
REQ-011 SHALL have port busy, output, 1, core stall request.
REQ-012 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 32), a one-cycle PC redirect.

Function
REQ-013 SHALL implement the states IDLE, EPC, CAUSE, VEC and RET, plus STATUS and RSTATUS when the macro is defined.
REQ-014 IDLE SHALL take the first true condition: req_ecall latches pc and goes to EPC; else req_mret goes to RET; else it stays in IDLE.
REQ-015 SHALL, in IDLE with no ecall/mret, pass req_csr_wen, req_csr_addr and req_csr_wdata through combinationally to csr_wen, csr_addr and csr_wdata.
REQ-016 SHALL suppress the CSR-instruction write (csr_wen=0) whenever req_ecall or req_mret is also high in IDLE, so a trap takes priority over a CSR write.
REQ-017 SHALL, in EPC, drive csr_addr=12'h341, csr_wdata=latched pc and csr_wen=1, then go to CAUSE.
REQ-018 SHALL, in CAUSE, drive csr_addr=12'h342, csr_wdata=ECALL_CAUSE and csr_wen=1, then go to STATUS when the macro is defined, else to VEC.
REQ-019 SHALL, in VEC, drive csr_addr=12'h305 and csr_wen=0, pulse redirect_valid=1 with redirect_pc=csr_rdata&MTVEC_ALIGN_MASK, then go to IDLE.
REQ-020 SHALL, in RET, drive csr_addr=12'h341 and csr_wen=0, pulse redirect_valid with redirect_pc=csr_rdata, then go to RSTATUS when the macro is defined, else to IDLE.
REQ-021 SHALL drive busy=(state!=IDLE) | (state==IDLE & (req_ecall|req_mret)).
REQ-022 SHALL ignore all req_* inputs outside IDLE; the core holds them while busy.
REQ-023 SHALL, with the macro undefined, give ecall latency of accept edge + 3 cycles to redirect (EPC, CAUSE, VEC) and mret latency of 1 cycle (RET).
REQ-024 SHALL drive redirect_valid high for exactly one cycle per trap or return, and never in IDLE.
REQ-025 SHALL accept back-to-back traps, so an ecall presented in the cycle after VEC returns to IDLE is accepted.
REQ-026 SHALL drive csr_addr=0, csr_wdata=0 and redirect_pc=0 when those outputs are not otherwise specified.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, go to IDLE, clear the latched pc and drive busy=0, redirect_valid=0 and csr_wen=0.
REQ-028 SHALL, on reset in the middle of a sequence, abandon it, skip any remaining CSR writes and issue no redirect.

Configuration
REQ-029 SHALL use the macro YSYX_23060240_TRAP_MSTATUS_EN to compile the mstatus update in or out.
REQ-030 SHALL, with the macro defined, in STATUS drive csr_addr=12'h300 and csr_wen=1 with csr_wdata = csr_rdata with MPIE(bit7)=MIE(bit3), MIE=0 and MPP(bits12:11)=2'b11, then go to VEC.
REQ-031 SHALL, with the macro defined, in RSTATUS drive csr_addr=12'h300 and csr_wen=1 with csr_wdata = csr_rdata with MIE=MPIE and MPIE=1, then go to IDLE.
REQ-032 SHALL, with the macro undefined, omit STATUS and RSTATUS and never address 12'h300 except through CSR-instruction pass-through.

Verification
REQ-033 Ecall, pc=32'h80000010, mtvec=32'h80000103 -> mepc write 32'h80000010, then mcause write 32'hb, then redirect to 32'h80000100 on the 3rd cycle after accept; busy is high from accept through VEC.
REQ-034 Mret with mepc=32'h80000014 -> redirect_valid 1 cycle after accept, redirect_pc=32'h80000014, csr_wen=0 (macro undefined).
REQ-035 req_ecall, req_mret and req_csr_wen (addr 12'h305) all high in IDLE -> ecall sequence only, no mtvec write, mret ignored.
REQ-036 rst_n=0 in CAUSE -> next cycle IDLE, no mcause write, no redirect, busy=0.
REQ-037 Macro defined, mstatus=32'h00000008, ecall -> mstatus write 32'h00001880; then mret -> mstatus write 32'h00001888.
REQ-038 CSR write to 12'h341 with data 32'h1234 in IDLE -> same-cycle csr_wen=1, csr_wdata=32'h1234, busy=0.

Source files
------------

// File: rtl/ysyx_23060240_trap_ctrl_if.sv
// ysyx_23060240_trap_ctrl_if: core request, CSR-file port and redirect signals of the trap controller
interface ysyx_23060240_trap_ctrl_if;
    logic        req_ecall;
    logic        req_mret;
    logic [31:0] pc;
    logic        req_csr_wen;
    logic [11:0] req_csr_addr;
    logic [31:0] req_csr_wdata;
    logic [31:0] csr_rdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    modport master (
        output req_ecall, req_mret, pc, req_csr_wen, req_csr_addr, req_csr_wdata, csr_rdata,
        input  csr_addr, csr_wdata, csr_wen, busy, redirect_valid, redirect_pc
    );
    modport slave (
        input  req_ecall, req_mret, pc, req_csr_wen, req_csr_addr, req_csr_wdata, csr_rdata,
        output csr_addr, csr_wdata, csr_wen, busy, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_23060240_trap_ctrl.sv
// ysyx_23060240_trap_ctrl: sequences ecall/mret CSR updates and PC redirect over one CSR port
// Define YSYX_23060240_TRAP_MSTATUS_EN to add the mstatus update steps.
module ysyx_23060240_trap_ctrl #(
    parameter logic [31:0] ECALL_CAUSE      = 32'h0000000b,
    parameter logic [31:0] MTVEC_ALIGN_MASK = 32'hfffffffc
) (
    input logic                     clk,
    input logic                     rst_n,
    ysyx_23060240_trap_ctrl_if.slave bus
);
`ifdef YSYX_23060240_TRAP_MSTATUS_EN
    typedef enum logic [2:0] {IDLE, EPC, CAUSE, VEC, RET, STATUS, RSTATUS} state_t;
`else
    typedef enum logic [2:0] {IDLE, EPC, CAUSE, VEC, RET} state_t;
`endif
    state_t      state, next;
    logic [31:0] epc;
    logic        trap;
    assign trap = bus.req_ecall | bus.req_mret;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            epc   <= '0;
        end else begin
            state <= next;
            if (state == IDLE && bus.req_ecall) epc <= bus.pc;
        end
    end
    always_comb begin
        next               = state;
        bus.csr_addr       = '0;
        bus.csr_wdata      = '0;
        bus.csr_wen        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.busy           = (state != IDLE) | trap;
        case (state)
            IDLE: begin
                next          = bus.req_ecall ? EPC : bus.req_mret ? RET : IDLE;
                bus.csr_addr  = trap ? 12'h0 : bus.req_csr_addr;
                bus.csr_wdata = trap ? 32'h0 : bus.req_csr_wdata;
                bus.csr_wen   = ~trap & bus.req_csr_wen;
            end
            EPC: begin
                next          = CAUSE;
                bus.csr_addr  = 12'h341;
                bus.csr_wdata = epc;
                bus.csr_wen   = 1'b1;
            end
            CAUSE: begin
`ifdef YSYX_23060240_TRAP_MSTATUS_EN
                next          = STATUS;
`else
                next          = VEC;
`endif
                bus.csr_addr  = 12'h342;
                bus.csr_wdata = ECALL_CAUSE;
                bus.csr_wen   = 1'b1;
            end
`ifdef YSYX_23060240_TRAP_MSTATUS_EN
            STATUS: begin
                next          = VEC;
                bus.csr_addr  = 12'h300;
                bus.csr_wdata = {bus.csr_rdata[31:13], 2'b11, bus.csr_rdata[10:8], bus.csr_rdata[3],
                                 bus.csr_rdata[6:4], 1'b0, bus.csr_rdata[2:0]};
                bus.csr_wen   = 1'b1;
            end
            RSTATUS: begin
                next          = IDLE;
                bus.csr_addr  = 12'h300;
                bus.csr_wdata = {bus.csr_rdata[31:8], 1'b1, bus.csr_rdata[6:4], bus.csr_rdata[7],
                                 bus.csr_rdata[2:0]};
                bus.csr_wen   = 1'b1;
            end
`endif
            VEC: begin
                next               = IDLE;
                bus.csr_addr       = 12'h305;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = bus.csr_rdata & MTVEC_ALIGN_MASK;
            end
            RET: begin
`ifdef YSYX_23060240_TRAP_MSTATUS_EN
                next               = RSTATUS;
`else
                next               = IDLE;
`endif
                bus.csr_addr       = 12'h341;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = bus.csr_rdata;
            end
            default: next = IDLE;
        endcase
        // An asserted reset must not let a pending CSR write or redirect escape.
        if (!rst_n) begin
            bus.csr_wen        = 1'b0;
            bus.redirect_valid = 1'b0;
            bus.busy           = 1'b0;
        end
    end
endmodule
